// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-side arbiter: N_REQ byte producers share one FIFO write port.
// A grant is held until the owner's last beat or MAX_BURST beats, whichever comes first.
module fifo_wr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  input  logic [N_REQ-1:0]          req_last,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      fifo_wr_en,
  output logic [DATA_W-1:0]         fifo_wr_data,
  input  logic                      fifo_full,
  output logic [$clog2(N_REQ)-1:0]  grant_id,
  output logic                      busy
);

  localparam int GW = $clog2(N_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, XFER} state_t;

  state_t            state, state_nxt;
  logic [GW-1:0]     grant_nxt, pick;
  logic [BW-1:0]     burst_cnt, cnt_nxt;
  logic [DATA_W-1:0] data_arr [N_REQ];
  logic              found;
  logic              cap_hit;

  function automatic logic [GW-1:0] rr_idx(input logic [GW-1:0] base, input int k);
    return GW'((int'(base) + k) % N_REQ);
  endfunction

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign data_arr[i] = req_data[i*DATA_W +: DATA_W];
  end

  // The previous owner is the lowest priority: scan starts one past grant_id.
  always_comb begin
    pick  = grant_id;
    found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!found && req_valid[rr_idx(grant_id, k)]) begin
        pick  = rr_idx(grant_id, k);
        found = 1'b1;
      end
    end
  end

  assign cap_hit = (burst_cnt == BW'(MAX_BURST - 1));

  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant_id;
    cnt_nxt      = burst_cnt;
    req_ready    = '0;
    fifo_wr_en   = 1'b0;
    fifo_wr_data = '0;
    busy         = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          grant_nxt = pick;
          cnt_nxt   = '0;
          state_nxt = XFER;
        end
      end
      XFER: begin
        busy                = 1'b1;
        req_ready[grant_id] = !fifo_full;
        fifo_wr_en          = req_valid[grant_id] & !fifo_full;
        if (fifo_wr_en) begin
          fifo_wr_data = data_arr[grant_id];
          cnt_nxt      = burst_cnt + 1'b1;
          if (req_last[grant_id] || cap_hit) begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      grant_id  <= GW'(N_REQ - 1);
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      grant_id  <= grant_nxt;
      burst_cnt <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: per-requester byte queues drive the handshake,
// FIFO writes are captured and compared against hand-ordered expected byte streams.
module tb_fifo_wr_arbiter;

  localparam int N_REQ     = 4;
  localparam int DATA_W    = 8;
  localparam int MAX_BURST = 16;
  localparam int GW        = 2;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [N_REQ-1:0]        req_valid, req_last, req_ready;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic                    fifo_wr_en, fifo_full, busy;
  logic [DATA_W-1:0]       fifo_wr_data;
  logic [GW-1:0]           grant_id;

  fifo_wr_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .fifo_full(fifo_full),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [N_REQ][32];
  logic       lst [N_REQ][32];
  int         head [N_REQ];
  int         tail [N_REQ];
  logic       hold [N_REQ];
  logic [7:0] cap [64];
  int         cap_n;
  logic [7:0] ex [64];
  int         ex_n;
  logic [63:0] wr_hist;
  logic       snap_wr, snap_busy;
  logic [7:0] snap_data;
  logic [3:0] snap_ready;
  logic [1:0] snap_grant;
  int         n_checks = 0;
  int         n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic push(input int r, input logic [7:0] d, input logic l);
    mem[r][tail[r]] = d;
    lst[r][tail[r]] = l;
    tail[r]++;
  endtask

  task automatic expect_byte(input logic [7:0] d);
    ex[ex_n] = d;
    ex_n++;
  endtask

  task automatic clear_log();
    cap_n   = 0;
    ex_n    = 0;
    wr_hist = '0;
  endtask

  task automatic drive();
    for (int i = 0; i < N_REQ; i++) begin
      req_valid[i] = 1'b0;
      req_last[i]  = 1'b0;
      req_data[i*DATA_W +: DATA_W] = '0;
      if (head[i] < tail[i] && !hold[i]) begin
        req_valid[i] = 1'b1;
        req_last[i]  = lst[i][head[i]];
        req_data[i*DATA_W +: DATA_W] = mem[i][head[i]];
      end
    end
  endtask

  // One clock: sample outputs at the falling edge, retire accepted beats after the rising edge.
  task automatic tick();
    logic [N_REQ-1:0] pop;
    @(negedge clk);
    snap_wr    = fifo_wr_en;
    snap_busy  = busy;
    snap_data  = fifo_wr_data;
    snap_ready = req_ready;
    snap_grant = grant_id;
    wr_hist    = {wr_hist[62:0], fifo_wr_en};
    pop        = req_valid & req_ready;
    if (fifo_wr_en && cap_n < 64) begin
      cap[cap_n] = fifo_wr_data;
      cap_n++;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N_REQ; i++) if (pop[i]) head[i]++;
    drive();
  endtask

  task automatic chk_stream(input string tag);
    chk({tag, "_count"}, cap_n, ex_n);
    for (int k = 0; k < ex_n; k++) chk({tag, "_byte"}, cap[k], ex[k]);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    fifo_full = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      head[i] = 0;
      tail[i] = 0;
      hold[i] = 1'b0;
    end
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_log();
    rst       = 1'b1;
    fifo_full = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      head[i] = 0;
      tail[i] = 0;
      hold[i] = 1'b0;
    end
    drive();
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_id, 3);
    chk("rst_wr_en", fifo_wr_en, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_wr_data", fifo_wr_data, 0);
    do_reset();

    // Single 3-byte packet from requester 0
    push(0, 8'h11, 1'b0); push(0, 8'h22, 1'b0); push(0, 8'h33, 1'b1);
    drive();
    tick(); chk("t1_idle_busy", snap_busy, 0); chk("t1_idle_wr", snap_wr, 0);
    tick(); chk("t1_b1_busy", snap_busy, 1); chk("t1_b1_data", snap_data, 8'h11);
            chk("t1_b1_grant", snap_grant, 0); chk("t1_b1_ready", snap_ready, 4'b0001);
    tick(); chk("t1_b2_wr", snap_wr, 1); chk("t1_b2_data", snap_data, 8'h22);
    tick(); chk("t1_b3_wr", snap_wr, 1); chk("t1_b3_data", snap_data, 8'h33);
    tick(); chk("t1_end_busy", snap_busy, 0); chk("t1_end_wr", snap_wr, 0);
            chk("t1_end_data", snap_data, 0); chk("t1_end_ready", snap_ready, 0);
    chk("t1_grant", grant_id, 0);

    // All four requesters, 2-byte packets, two rounds from reset
    do_reset();
    clear_log();
    for (int r = 0; r < N_REQ; r++) begin
      push(r, 8'hA0 + 8'(r*16), 1'b0); push(r, 8'hA1 + 8'(r*16), 1'b1);
      expect_byte(8'hA0 + 8'(r*16)); expect_byte(8'hA1 + 8'(r*16));
    end
    drive();
    repeat (13) tick();
    chk("t2_gaps_r1", wr_hist[12:0], 13'b0110110110110);
    chk_stream("t2_order_r1");
    clear_log();
    for (int r = 0; r < N_REQ; r++) begin
      push(r, 8'h05 + 8'(r*16), 1'b0); push(r, 8'h06 + 8'(r*16), 1'b1);
      expect_byte(8'h05 + 8'(r*16)); expect_byte(8'h06 + 8'(r*16));
    end
    drive();
    repeat (13) tick();
    chk("t2_gaps_r2", wr_hist[12:0], 13'b0110110110110);
    chk_stream("t2_order_r2");

    // Requester 1, 5 bytes, FIFO full during XFER cycles 2-4
    clear_log();
    for (int k = 0; k < 5; k++) begin
      push(1, 8'hB0 + 8'(k), k == 4);
      expect_byte(8'hB0 + 8'(k));
    end
    drive();
    tick(); chk("t3_idle_busy", snap_busy, 0);
    tick(); chk("t3_b1_data", snap_data, 8'hB0); chk("t3_b1_grant", snap_grant, 1);
    fifo_full = 1'b1;
    repeat (3) begin
      tick();
      chk("t3_full_wr", snap_wr, 0); chk("t3_full_ready", snap_ready, 0); chk("t3_full_busy", snap_busy, 1);
    end
    fifo_full = 1'b0;
    repeat (4) begin
      tick(); chk("t3_resume_wr", snap_wr, 1);
    end
    tick(); chk("t3_end_busy", snap_busy, 0);
    chk_stream("t3_stream");

    // Burst cap: requester 2 streams 20 bytes, requester 3 waits
    clear_log();
    for (int k = 0; k < 20; k++) push(2, 8'h40 + 8'(k), k == 19);
    push(3, 8'hE0, 1'b0); push(3, 8'hE1, 1'b1);
    for (int k = 0; k < 16; k++) expect_byte(8'h40 + 8'(k));
    expect_byte(8'hE0); expect_byte(8'hE1);
    for (int k = 16; k < 20; k++) expect_byte(8'h40 + 8'(k));
    drive();
    repeat (26) tick();
    chk("t4_gaps", wr_hist[25:0], 26'b0_1111111111111111_0_11_0_1111_0);
    chk_stream("t4_stream");
    chk("t4_grant", grant_id, 2);

    // Reset in the middle of a requester-0 packet
    for (int k = 0; k < 4; k++) push(0, 8'h70 + 8'(k), k == 3);
    drive();
    tick(); tick(); tick();
    chk("t5_pre_data", snap_data, 8'h71);
    rst = 1'b1;
    #1;
    chk("t5_rst_wr", fifo_wr_en, 0); chk("t5_rst_ready", req_ready, 0);
    chk("t5_rst_busy", busy, 0); chk("t5_rst_grant", grant_id, 3); chk("t5_rst_data", fifo_wr_data, 0);
    clear_log();
    push(1, 8'h81, 1'b1);
    drive();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    expect_byte(8'h72); expect_byte(8'h73); expect_byte(8'h81);
    tick(); chk("t5_first_grant", snap_grant, 0); chk("t5_first_data", snap_data, 8'h72);
    repeat (4) tick();
    chk_stream("t5_stream");

    // Owner stalls for 3 cycles while requester 1 waits
    clear_log();
    for (int k = 0; k < 4; k++) push(2, 8'h91 + 8'(k), k == 3);
    push(1, 8'hC1, 1'b0); push(1, 8'hC2, 1'b1);
    expect_byte(8'h91); expect_byte(8'h92); expect_byte(8'h93); expect_byte(8'h94);
    expect_byte(8'hC1); expect_byte(8'hC2);
    drive();
    tick(); tick(); chk("t6_grant", snap_grant, 2);
    tick();
    hold[2] = 1'b1;
    drive();
    repeat (3) begin
      tick();
      chk("t6_stall_wr", snap_wr, 0); chk("t6_stall_busy", snap_busy, 1);
      chk("t6_stall_ready", snap_ready, 4'b0100);
    end
    hold[2] = 1'b0;
    drive();
    repeat (6) tick();
    chk_stream("t6_stream");
    chk("t6_final_grant", grant_id, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write-side arbiter that shares one 8-bit byte FIFO (1024 entries, registered write, active-high full) among N_REQ producers. Each producer presents bytes with a valid/ready handshake and a last flag. The arbiter grants one producer at a time and holds the grant until that producer's packet ends or a fairness cap is reached. It drives the FIFO write port directly and honours fifo_full backpressure.

Parameters:
N_REQ, 4, number of requesters (2..8)
DATA_W, 8, byte width, matches FIFO data width
MAX_BURST, 16, max beats per grant before forced release (1..255)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  N_REQ  per-requester byte valid
req_data  input  N_REQ*DATA_W  per-requester byte, requester i at bits [i*DATA_W +: DATA_W]
req_last  input  N_REQ  marks final byte of requester's packet
req_ready  output  N_REQ  per-requester accept; beat transfers when valid&ready
fifo_wr_en  output  1  FIFO write strobe
fifo_wr_data  output  DATA_W  FIFO write byte
fifo_full  input  1  FIFO full flag
grant_id  output  clog2(N_REQ)  current/last owner index
busy  output  1  high while a grant is held (state XFER)

Behaviour:
- Reset (async): state=IDLE, grant_id=N_REQ-1 (so requester 0 has top priority first), burst_cnt=0, busy=0. req_ready, fifo_wr_en=0 immediately. fifo_wr_data=0 whenever fifo_wr_en=0.
- States: IDLE, XFER.
- IDLE: if any req_valid, choose first i with req_valid[i]=1, scanning grant_id+1, grant_id+2, ... mod N_REQ. Next edge: grant_id<=i, burst_cnt<=0, state<=XFER. If no valid, stay IDLE. No transfers in IDLE.
- XFER (combinational outputs): req_ready[grant_id] = !fifo_full; all other req_ready=0. fifo_wr_en = req_valid[grant_id] & !fifo_full. fifo_wr_data = req_data[grant_id] when fifo_wr_en, else 0.
- Beat = fifo_wr_en high at a rising edge; burst_cnt increments by 1 per beat. burst_cnt width clog2(MAX_BURST+1), never wraps.
- Release: on a beat with req_last[grant_id]=1 OR burst_cnt+1==MAX_BURST -> state<=IDLE, grant_id holds owner (becomes round-robin pointer).
- Arbitration cost: exactly one IDLE cycle between grants; the first beat of a new grant occurs no earlier than 2 cycles after valid is first seen in IDLE.
- Owner deasserts valid mid-packet: grant held, no beat, no timeout.
- fifo_full in XFER: no beat, counter unchanged, grant held. Write resumes on the first cycle fifo_full=0.
- Cap release without last: the remainder of the packet is re-arbitrated normally. If other requesters are valid, they are served first.
- Non-owner valid/last/data: ignored, never written.
- Reset mid-XFER: outputs drop asynchronously. Any partial packet in the FIFO is not the arbiter's concern.
- Throughput: 1 byte/cycle within a grant when valid and FIFO not full.

Test Plan:
- Req0 sends 0x11,0x22,0x33 (last on 0x33), FIFO empty -> busy rises 1 cycle after valid; 3 consecutive fifo_wr_en pulses with data 0x11,0x22,0x33; grant_id=0; IDLE after beat 3.
- Req0..3 all valid with 2-byte packets from reset -> FIFO receives packets in order 0,1,2,3. Re-asserting all four then serves 0,1,2,3 again. Exactly one idle cycle between packets.
- Req1 packet of 5 bytes, fifo_full high for cycles 2-4 of XFER -> req_ready[1]=0 and fifo_wr_en=0 during full; all 5 bytes written in order, none lost or duplicated.
- MAX_BURST=16: req2 streams 20 bytes without last while req3 is valid -> 16 bytes from req2, release, req3 packet, then req2's remaining 4 bytes.
- Assert rst after 2 of 4 bytes of a req0 packet -> fifo_wr_en and req_ready drop same cycle; after release, the next grant starts from requester 0 (grant_id=3 pointer).
- Owner drops valid for 3 cycles mid-packet while req1 is valid -> no writes from req1; owner resumes and completes, then req1 is granted.
